// File: rtl/compare_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : compare_serial_if
//  Description : Request/response bundle for the serial magnitude comparator.
//                The master issues start with operands and signedness; the
//                slave returns busy/done and the eq/lt/gt result flags.
//  Ports       : start, signed_mode, a[WIDTH-1:0], b[WIDTH-1:0]  (master->slave)
//                busy, done, eq, lt, gt                          (slave->master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface compare_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             lt;
    logic             gt;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, eq, lt, gt
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, eq, lt, gt
    );
endinterface
`default_nettype wire

// File: rtl/compare_serial.sv
`default_nettype none
// ============================================================================
//  Module      : compare_serial
//  Description : Sequential WIDTH-bit comparator producing eq/lt/gt for
//                signed or unsigned operands. Operands are walked MSB-first,
//                STEP bits per clock, stopping at the first differing chunk.
//  Ports       : clk    - clock, rising-edge active
//                reset  - asynchronous active-high reset
//                bus    - compare_serial_if.slave
//                         start/signed_mode/a/b in, busy/done/eq/lt/gt out
//  Revision    : 1.0 - initial release
// ============================================================================
module compare_serial #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  wire              clk,
    input  wire              reset,
    compare_serial_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------------
    if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
        $error("compare_serial: WIDTH must be >= 2 and a multiple of STEP");
    end

    localparam int c_NCHUNK = WIDTH / STEP;
    localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;

    // Inverting the sign bit maps two's-complement onto offset binary, so a
    // plain unsigned chunk walk yields the signed ordering.
    localparam logic [WIDTH-1:0] c_MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_eq;
    logic               r_lt;
    logic               r_gt;

    logic               w_accept;
    logic [STEP-1:0]    w_chunk_a;
    logic [STEP-1:0]    w_chunk_b;
    logic               w_differ;
    logic               w_last;
    logic [WIDTH-1:0]   w_flip;

    // ------------------------------------------------------------------------
    // Datapath decode
    // ------------------------------------------------------------------------
    // The latched operands are shifted left after every equal chunk, so the
    // chunk under test always sits in the top STEP bits.
    assign w_chunk_a = r_a[WIDTH-1 -: STEP];
    assign w_chunk_b = r_b[WIDTH-1 -: STEP];
    assign w_differ  = (w_chunk_a != w_chunk_b);
    assign w_last    = (r_idx == c_LAST_IDX);
    assign w_flip    = bus.signed_mode ? c_MSB_MASK : '0;

    // A start is honoured only when no comparison is in flight.
    assign w_accept  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_differ || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A start on the done edge chains straight into a new run.
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand, index and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.a ^ w_flip;
            r_b   <= bus.b ^ w_flip;
            r_idx <= '0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_differ) begin
                // First differing chunk decides the ordering outright.
                r_gt <= (w_chunk_a > w_chunk_b);
                r_lt <= (w_chunk_a < w_chunk_b);
            end else if (w_last) begin
                r_eq <= 1'b1;
            end else begin
                r_idx <= r_idx + c_IDX_W'(1);
                r_a   <= r_a << STEP;
                r_b   <= r_b << STEP;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from flops)
    // ------------------------------------------------------------------------
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.eq   = r_eq;
    assign bus.lt   = r_lt;
    assign bus.gt   = r_gt;

endmodule
`default_nettype wire

// File: tb/tb_compare_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compare_serial
//  Description : Self-checking bench for compare_serial. Two instances
//                (STEP=1 and STEP=4, WIDTH=8) share one stimulus stream; an
//                arithmetic reference model predicts every output each cycle,
//                and directed vectors carry hand-computed latency/flag values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_compare_serial;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    compare_serial_if #(.WIDTH(8)) if1 ();
    compare_serial_if #(.WIDTH(8)) if4 ();

    assign if1.start       = start;
    assign if1.signed_mode = signed_mode;
    assign if1.a           = a;
    assign if1.b           = b;
    assign if4.start       = start;
    assign if4.signed_mode = signed_mode;
    assign if4.a           = a;
    assign if4.b           = b;

    compare_serial #(.WIDTH(8), .STEP(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    compare_serial #(.WIDTH(8), .STEP(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    // ------------------------------------------------------------------------
    // Checking helper
    // ------------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: result from plain arithmetic, busy length from the
    // position of the first differing STEP-bit chunk of a^b.
    // ------------------------------------------------------------------------
    function automatic int first_diff(input logic [7:0] x, input logic [7:0] y, input int step);
        logic [7:0] d;
        logic [7:0] t;
        d = x ^ y;
        for (int i = 0; i < 8 / step; i++) begin
            t = d << (i * step);
            if ((t >> (8 - step)) != 8'h00) return i + 1;
        end
        return 8 / step;
    endfunction

    // Returns {eq, lt, gt}
    function automatic logic [2:0] ref_result(input logic [7:0] x, input logic [7:0] y, input logic sm);
        if (x == y) return 3'b100;
        if (sm) return ($signed(x) < $signed(y)) ? 3'b010 : 3'b001;
        return (x < y) ? 3'b010 : 3'b001;
    endfunction

    int         m_left [2] = '{0, 0};
    logic       m_done [2] = '{1'b0, 1'b0};
    logic [2:0] m_res  [2] = '{3'b000, 3'b000};
    logic [2:0] m_flags[2] = '{3'b000, 3'b000};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_left[k]  = 0;
                m_done[k]  = 1'b0;
                m_flags[k] = 3'b000;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_left[k] == 0 && start) begin
                    m_left[k]  = first_diff(a, b, (k == 1) ? 4 : 1);
                    m_res[k]   = ref_result(a, b, signed_mode);
                    m_done[k]  = 1'b0;
                    m_flags[k] = 3'b000;
                end else if (m_left[k] > 0) begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        m_done[k]  = 1'b1;
                        m_flags[k] = m_res[k];
                    end
                end else begin
                    m_done[k] = 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("d1_busy",  if1.busy, m_left[0] > 0);
        chk("d1_done",  if1.done, m_done[0]);
        chk("d1_flags", {if1.eq, if1.lt, if1.gt}, m_flags[0]);
        chk("d4_busy",  if4.busy, m_left[1] > 0);
        chk("d4_done",  if4.done, m_done[1]);
        chk("d4_flags", {if4.eq, if4.lt, if4.gt}, m_flags[1]);
    end

    // ------------------------------------------------------------------------
    // Directed stimulus helpers (called at a falling edge)
    // ------------------------------------------------------------------------
    function automatic logic sel_done(input int sel);
        return (sel == 1) ? if4.done : if1.done;
    endfunction

    function automatic logic [2:0] sel_flags(input int sel);
        return (sel == 1) ? {if4.eq, if4.lt, if4.gt} : {if1.eq, if1.lt, if1.gt};
    endfunction

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while ((if1.busy || if4.busy || if1.done || if4.done) && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Latency counts rising edges from the accepting edge (edge 0) to the
    // edge after which done is seen high.
    task automatic run_cmp(input logic [7:0] ta, input logic [7:0] tb_v, input logic sm,
                           input int sel, input int exp_lat, input logic [2:0] exp_fl,
                           input string nm);
        int lat;
        a = ta;
        b = tb_v;
        signed_mode = sm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!sel_done(sel) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_flags"}, sel_flags(sel), exp_fl);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int lat;

        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_d1_out", {if1.busy, if1.done, if1.eq, if1.lt, if1.gt}, 5'b00000);
        chk("rst_d4_out", {if4.busy, if4.done, if4.eq, if4.lt, if4.gt}, 5'b00000);
        @(negedge clk);
        reset = 1'b0;

        // Start on the first edge after reset release; equal operands.
        run_cmp(8'h44, 8'h44, 1'b0, 0, 9, 3'b100, "eq44");
        chk("eq44_hold", {if1.eq, if1.lt, if1.gt}, 3'b100);

        // Signed vs unsigned ordering
        run_cmp(8'h80, 8'h7F, 1'b0, 0, 2, 3'b001, "u80_7f");
        run_cmp(8'h80, 8'h7F, 1'b1, 0, 2, 3'b010, "s80_7f");
        run_cmp(8'hFF, 8'h01, 1'b1, 0, 2, 3'b010, "sff_01");

        // Difference only in the LSB: worst-case latency
        run_cmp(8'h0B, 8'h0A, 1'b0, 0, 9, 3'b001, "lsb");

        // start re-pulsed two cycles into a run is ignored
        a = 8'h01; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        @(negedge clk);
        lat = 2;
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!if1.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_lat", lat, 9);
        chk("ignore_flags", {if1.eq, if1.lt, if1.gt}, 3'b001);
        wait_idle();

        // start held high through done: back-to-back accept
        a = 8'h80; b = 8'h7F; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h10; b = 8'h20;
        @(negedge clk);
        chk("b2b_done1", if1.done, 1'b1);
        chk("b2b_flags1", {if1.eq, if1.lt, if1.gt}, 3'b001);
        @(negedge clk);
        chk("b2b_restart", {if1.busy, if1.done, if1.eq, if1.lt, if1.gt}, 5'b10000);
        start = 1'b0;
        wait_idle();
        chk("b2b_flags2", {if1.eq, if1.lt, if1.gt}, 3'b010);

        // Reset three cycles into a run
        a = 8'h01; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", if1.busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_d1_out", {if1.busy, if1.done, if1.eq, if1.lt, if1.gt}, 5'b00000);
        chk("midrst_d4_out", {if4.busy, if4.done, if4.eq, if4.lt, if4.gt}, 5'b00000);
        @(negedge clk);
        reset = 1'b0;
        run_cmp(8'h10, 8'h20, 1'b0, 0, 4, 3'b010, "post_rst");

        // STEP=4 instance
        run_cmp(8'h58, 8'h5A, 1'b0, 1, 3, 3'b010, "w4_lt");
        run_cmp(8'hC3, 8'hC3, 1'b0, 1, 3, 3'b100, "w4_eq");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
